// File: rtl/memory_arbiter_pkg.sv
// Shared CPU constants used by the memory arbiter: word width, byte-strobe
// width, load/store type codes and the grant vector layout.
package memory_arbiter_pkg;

    localparam int CPU_XLEN   = 32;
    localparam int CPU_STRB_W = CPU_XLEN / 8;

    typedef enum logic {
        LS_LOAD  = 1'b0,
        LS_STORE = 1'b1
    } lsType_e;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grantee_e;

    // Bit positions inside the one-hot grant vector.
    localparam int GRANT_INSTR_BIT = 0;
    localparam int GRANT_DATA_BIT  = 1;

endpackage

// File: rtl/memory_arbiter_grant.sv
// Combinational grant selection: data has priority over fetch, except when the
// data streak has reached its limit while a fetch is waiting.
module memory_arbiter_grant
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 2,
    parameter int STREAK_W        = 2
) (
    input  logic                instrValid_i,
    input  logic                dataValid_i,
    input  logic [STREAK_W-1:0] streak_i,
    input  logic                idle_i,
    output logic [1:0]          grant_o
);

    logic streakFull;

    assign streakFull = (streak_i == STREAK_W'(MAX_DATA_STREAK));

    always_comb begin
        grant_o = '0;
        if (idle_i) begin
            if (dataValid_i && !(instrValid_i && streakFull)) begin
                grant_o[GRANT_DATA_BIT] = 1'b1;
            end else if (instrValid_i) begin
                grant_o[GRANT_INSTR_BIT] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares a single-port synchronous memory between instruction fetch and
// load/store, one access per IDLE -> MEM -> RESP round.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int XLEN            = CPU_XLEN,
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_DATA_STREAK = 2
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,

    input  logic                  i_Instr_Req_Valid,
    output logic                  o_Instr_Req_Ready,
    input  logic [XLEN-1:0]       i_Instr_Addr,
    output logic                  o_Instr_Resp_Valid,
    output logic [XLEN-1:0]       o_Instr_Resp_Data,

    input  logic                  i_Data_Req_Valid,
    output logic                  o_Data_Req_Ready,
    input  logic                  i_Data_Write_Enable,
    input  logic [XLEN-1:0]       i_Data_Addr,
    input  logic [XLEN-1:0]       i_Data_Write_Data,
    input  logic [XLEN/8-1:0]     i_Data_Byte_Enable,
    output logic                  o_Data_Resp_Valid,
    output logic [XLEN-1:0]       o_Data_Resp_Data,

    output logic                  o_Mem_Enable,
    output logic [XLEN/8-1:0]     o_Mem_Write_Strobe,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic [XLEN-1:0]       o_Mem_Write_Data,
    input  logic [XLEN-1:0]       i_Mem_Read_Data
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic [STREAK_W-1:0]   streak_q;
    logic [STREAK_W-1:0]   streak_d;
    grantee_e              grantee_q;
    lsType_e               writeType_q;
    logic                  memEnable_q;
    logic [XLEN/8-1:0]     strobe_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [XLEN-1:0]       memWData_q;

    logic [1:0] grant;
    logic       idleOffer;
    logic       respPhase;

    // Ready is withheld during reset so a request presented alongside reset is never handshaken.
    assign idleOffer = (state_q == ST_IDLE) && !i_Reset;

    memory_arbiter_grant #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK),
        .STREAK_W        (STREAK_W)
    ) u_grant (
        .instrValid_i (i_Instr_Req_Valid),
        .dataValid_i  (i_Data_Req_Valid),
        .streak_i     (streak_q),
        .idle_i       (idleOffer),
        .grant_o      (grant)
    );

    // The streak only counts data grants made while a fetch was actually waiting.
    always_comb begin
        streak_d = streak_q;
        if (grant[GRANT_DATA_BIT] && i_Instr_Req_Valid) begin
            if (streak_q != STREAK_W'(MAX_DATA_STREAK)) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (grant[GRANT_INSTR_BIT] || (state_q == ST_IDLE && !i_Instr_Req_Valid)) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            grantee_q   <= GRANT_INSTR;
            writeType_q <= LS_LOAD;
            memEnable_q <= 1'b0;
            strobe_q    <= '0;
            memAddr_q   <= '0;
            memWData_q  <= '0;
        end else begin
            streak_q <= streak_d;
            case (state_q)
                ST_IDLE: begin
                    if (grant[GRANT_DATA_BIT]) begin
                        state_q     <= ST_MEM;
                        memEnable_q <= 1'b1;
                        grantee_q   <= GRANT_DATA;
                        writeType_q <= i_Data_Write_Enable ? LS_STORE : LS_LOAD;
                        strobe_q    <= i_Data_Write_Enable ? i_Data_Byte_Enable : '0;
                        memAddr_q   <= i_Data_Addr[ADDR_WIDTH+1:2];
                        memWData_q  <= i_Data_Write_Data;
                    end else if (grant[GRANT_INSTR_BIT]) begin
                        state_q     <= ST_MEM;
                        memEnable_q <= 1'b1;
                        grantee_q   <= GRANT_INSTR;
                        writeType_q <= LS_LOAD;
                        strobe_q    <= '0;
                        memAddr_q   <= i_Instr_Addr[ADDR_WIDTH+1:2];
                        memWData_q  <= '0;
                    end
                end
                ST_MEM: begin
                    state_q     <= ST_RESP;
                    memEnable_q <= 1'b0;
                    strobe_q    <= '0;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Instr_Req_Ready = grant[GRANT_INSTR_BIT];
    assign o_Data_Req_Ready  = grant[GRANT_DATA_BIT];

    assign respPhase          = (state_q == ST_RESP);
    assign o_Instr_Resp_Valid = respPhase && (grantee_q == GRANT_INSTR);
    assign o_Data_Resp_Valid  = respPhase && (grantee_q == GRANT_DATA);
    assign o_Instr_Resp_Data  = o_Instr_Resp_Valid ? i_Mem_Read_Data : '0;
    assign o_Data_Resp_Data   = (o_Data_Resp_Valid && writeType_q == LS_LOAD) ? i_Mem_Read_Data : '0;

    assign o_Mem_Enable       = memEnable_q;
    assign o_Mem_Write_Strobe = strobe_q;
    assign o_Mem_Addr         = memAddr_q;
    assign o_Mem_Write_Data   = memWData_q;

    // Byte offset and high address bits are deliberately dropped so addresses wrap.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{i_Instr_Addr[XLEN-1:ADDR_WIDTH+2], i_Instr_Addr[1:0],
                              i_Data_Addr[XLEN-1:ADDR_WIDTH+2], i_Data_Addr[1:0]};

endmodule
